// File: rtl/imm_ext_stage.sv
// imm_ext_stage
// Registered immediate-extension stage between decode and the ID/EX register.
// The raw immediate is extended before storage, so the main and skid registers
// both hold final out_data/out_err values. A two-entry skid buffer with a
// registered in_ready absorbs downstream stalls without a combinational
// ready path back into decode.
//
// Optional feature macro: IMM_EXT_BRANCH_ADD_EN
//   defined   : mode 4 (BRANCH) resolves in_pc + 4 + (sext(in_imm) << 2)
//   undefined : no adder is built, in_pc is ignored, mode 4 behaves as SHIFT2
//
// DATA_W must be at least IMM_W + 2.

module imm_ext_stage #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [2:0]        in_mode,
    input  logic [DATA_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    localparam int FILL_W = DATA_W - IMM_W;

    localparam logic [2:0] MODE_ZERO    = 3'd0;
    localparam logic [2:0] MODE_SIGNED  = 3'd1;
    localparam logic [2:0] MODE_HIGHPOS = 3'd2;
    localparam logic [2:0] MODE_SHIFT2  = 3'd3;
    localparam logic [2:0] MODE_BRANCH  = 3'd4;
    localparam logic [2:0] MODE_ONES    = 3'd5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // main register invalid
        ST_ONE   = 2'd1,   // main valid, skid empty
        ST_FULL  = 2'd2    // main and skid both valid
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_in_ready;
    logic [DATA_W-1:0]   r_main_data;
    logic                r_main_err;
    logic [DATA_W-1:0]   r_skid_data;
    logic                r_skid_err;

    logic                w_take_in;
    logic                w_drain;
    logic                w_load_main_new;
    logic                w_load_main_skid;
    logic                w_load_skid;

    logic [DATA_W-1:0]   w_zext;
    logic [DATA_W-1:0]   w_sext;
    logic [DATA_W-1:0]   w_high;
    logic [DATA_W-1:0]   w_shift2;
    logic [DATA_W-1:0]   w_ones;
    logic [DATA_W-1:0]   w_branch;
    logic [DATA_W-1:0]   w_ext_data;
    logic                w_ext_err;

    // ------------------------------------------------------------------
    // Extension datapath (purely combinational, ahead of the registers)
    // ------------------------------------------------------------------
    assign w_zext   = {{FILL_W{1'b0}}, in_imm};
    assign w_sext   = {{FILL_W{in_imm[IMM_W-1]}}, in_imm};
    assign w_high   = {in_imm, {FILL_W{1'b0}}};
    assign w_shift2 = w_sext << 2;       // bits leaving the MSB end are dropped
    assign w_ones   = {{FILL_W{1'b1}}, in_imm};

`ifdef IMM_EXT_BRANCH_ADD_EN
    // Branch target: PC of the branch plus 4 plus the word offset, mod 2^DATA_W
    assign w_branch = in_pc + DATA_W'(4) + w_shift2;
`else
    // No branch adder: mode 4 aliases SHIFT2 and the PC input is ignored
    assign w_branch = w_shift2;
    logic  w_unused_pc;
    assign w_unused_pc = ^in_pc;
`endif

    // Select the extended operand; reserved modes give zero data and flag err
    always_comb begin
        w_ext_data = '0;
        w_ext_err  = 1'b0;
        case (in_mode)
            MODE_ZERO:    w_ext_data = w_zext;
            MODE_SIGNED:  w_ext_data = w_sext;
            MODE_HIGHPOS: w_ext_data = w_high;
            MODE_SHIFT2:  w_ext_data = w_shift2;
            MODE_BRANCH:  w_ext_data = w_branch;
            MODE_ONES:    w_ext_data = w_ones;
            default:      w_ext_err  = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake and skid-buffer control
    // ------------------------------------------------------------------
    assign w_take_in = in_valid && r_in_ready && !flush;
    assign w_drain   = (r_state != ST_EMPTY) && out_ready;

    // Next state and register-load selects for the two-entry buffer
    always_comb begin
        w_state_next     = r_state;
        w_load_main_new  = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_take_in) begin
                    w_state_next    = ST_ONE;
                    w_load_main_new = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_take_in && !w_drain) begin
                    w_state_next = ST_FULL;
                    w_load_skid  = 1'b1;
                end else if (w_take_in && w_drain) begin
                    w_state_next    = ST_ONE;
                    w_load_main_new = 1'b1;
                end else if (w_drain) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a drain can move the state
                if (w_drain) begin
                    w_state_next     = ST_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    // State, ready and data registers; flush and reset produce the same result
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_main_data <= '0;
            r_main_err  <= 1'b0;
            r_skid_data <= '0;
            r_skid_err  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != ST_FULL);
            if (w_load_main_new) begin
                r_main_data <= w_ext_data;
                r_main_err  <= w_ext_err;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_err  <= r_skid_err;
            end
            if (w_load_skid) begin
                r_skid_data <= w_ext_data;
                r_skid_err  <= w_ext_err;
            end
        end
    end

    // Outputs come straight from registers; data holds while stalled
    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_main_data;
    assign out_err   = r_main_err;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Directed testbench for imm_ext_stage: inputs are driven and outputs are
// sampled on the falling edge, one line printed per checked transaction.
`timescale 1ns/1ps

module tb_imm_ext_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [2:0]  in_mode;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imm_ext_stage #(.DATA_W(32), .IMM_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // advance one full cycle, landing on the next falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [2:0] m, input logic [15:0] imm);
        in_valid = v;
        in_mode  = m;
        in_imm   = imm;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; in_pc = 32'h0;
        drive(1'b1, 3'd0, 16'h1234);

        // reset held 3 cycles with a beat presented
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_valid", {31'b0, out_valid}, 32'h0);
            chk("rst_data",  out_data, 32'h0);
            chk("rst_err",   {31'b0, out_err}, 32'h0);
        end
        rst_n = 1'b1;
        drive(1'b0, 3'd0, 16'h0);
        step();
        chk("rel_ready", {31'b0, in_ready}, 32'h1);
        chk("rel_valid", {31'b0, out_valid}, 32'h0);

        // all legal modes back-to-back at full rate
        drive(1'b1, 3'd0, 16'h8001); step(); chk("m_zero",    out_data, 32'h0000_8001);
        chk("m_zero_v", {31'b0, out_valid}, 32'h1);
        drive(1'b1, 3'd1, 16'h8001); step(); chk("m_signed",  out_data, 32'hFFFF_8001);
        drive(1'b1, 3'd2, 16'h8001); step(); chk("m_highpos", out_data, 32'h8001_0000);
        drive(1'b1, 3'd3, 16'h8001); step(); chk("m_shift2",  out_data, 32'hFFFE_0004);
        drive(1'b1, 3'd5, 16'h8001); step(); chk("m_ones",    out_data, 32'hFFFF_8001);
        chk("m_ones_err", {31'b0, out_err}, 32'h0);
        drive(1'b0, 3'd0, 16'h0);    step(); chk("m_drained", {31'b0, out_valid}, 32'h0);
        chk("m_hold", out_data, 32'hFFFF_8001);

        // backpressure: A, B fill the buffer, C must wait
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 16'h0001); step();
        chk("bp_a_data", out_data, 32'h1);
        chk("bp_a_rdy",  {31'b0, in_ready}, 32'h1);
        drive(1'b1, 3'd0, 16'h0002); step();
        chk("bp_full_data", out_data, 32'h1);
        chk("bp_full_rdy",  {31'b0, in_ready}, 32'h0);
        drive(1'b1, 3'd0, 16'h0003); step();
        chk("bp_c_blocked", out_data, 32'h1);
        chk("bp_c_rdy",     {31'b0, in_ready}, 32'h0);
        out_ready = 1'b1; step();
        chk("bp_b", out_data, 32'h2);
        chk("bp_b_rdy", {31'b0, in_ready}, 32'h1);
        step();
        chk("bp_c", out_data, 32'h3);
        drive(1'b0, 3'd0, 16'h0); step();
        chk("bp_empty", {31'b0, out_valid}, 32'h0);

        // flush while FULL with a beat presented
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 16'h0011); step();
        drive(1'b1, 3'd6, 16'h0022); step();
        chk("fl_full_rdy", {31'b0, in_ready}, 32'h0);
        drive(1'b1, 3'd0, 16'h0033); flush = 1'b1; step();
        flush = 1'b0;
        chk("fl_valid", {31'b0, out_valid}, 32'h0);
        chk("fl_ready", {31'b0, in_ready}, 32'h1);
        chk("fl_data",  out_data, 32'h0);
        chk("fl_err",   {31'b0, out_err}, 32'h0);
        drive(1'b0, 3'd0, 16'h0); out_ready = 1'b1; step();
        chk("fl_gone", {31'b0, out_valid}, 32'h0);

        // branch mode
        in_pc = 32'h0040_0000;
        drive(1'b1, 3'd4, 16'hFFFF); step();
`ifdef IMM_EXT_BRANCH_ADD_EN
        chk("br_target", out_data, 32'h0040_0000);
`else
        chk("br_shift2", out_data, 32'hFFFF_FFFC);
`endif
        in_pc = 32'h0;

        // reserved modes then recovery
        drive(1'b1, 3'd6, 16'hFFFF); step();
        chk("rsv6_data", out_data, 32'h0);
        chk("rsv6_err",  {31'b0, out_err}, 32'h1);
        drive(1'b1, 3'd7, 16'h1234); step();
        chk("rsv7_err",  {31'b0, out_err}, 32'h1);
        drive(1'b1, 3'd0, 16'h00FF); step();
        chk("rsv_clr_data", out_data, 32'h0000_00FF);
        chk("rsv_clr_err",  {31'b0, out_err}, 32'h0);

        // reset mid-stream while FULL, together with flush
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 16'h7000); step();
        chk("mr_full_rdy", {31'b0, in_ready}, 32'h0);
        rst_n = 1'b0; flush = 1'b1; step();
        rst_n = 1'b1; flush = 1'b0;
        chk("mr_valid", {31'b0, out_valid}, 32'h0);
        chk("mr_ready", {31'b0, in_ready}, 32'h1);
        chk("mr_data",  out_data, 32'h0);
        drive(1'b0, 3'd0, 16'h0); out_ready = 1'b1; step();
        chk("mr_gone", {31'b0, out_valid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imm_ext_stage.md
# imm_ext_stage

Parametrised, registered immediate-extension stage sitting between instruction decode and the ID/EX pipeline register of the pipelined MIPS core. Accepts a raw immediate, an extension mode and the instruction PC under a valid/ready handshake. Produces the extended (and optionally branch-target-resolved) operand one cycle later. A two-entry skid buffer absorbs EX-side stalls without a combinational ready path back into decode.

## Interface
- DATA_W, 32, output operand width; must satisfy DATA_W >= IMM_W + 2
- IMM_W, 16, raw immediate width
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- flush  input  1  discard all buffered entries (branch mispredict / exception)
- in_valid  input  1  upstream beat present
- in_ready  output  1  stage can accept a beat (registered)
- in_imm  input  IMM_W  raw immediate field
- in_mode  input  3  extension mode (see Operation)
- in_pc  input  DATA_W  PC of the instruction carrying the immediate
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts
- out_data  output  DATA_W  extended operand
- out_err  output  1  beat carried a reserved mode

## Operation
- Modes: 0 ZERO = zero-extend; 1 SIGNED = sign-extend from in_imm[IMM_W-1]; 2 HIGHPOS = {in_imm, (DATA_W-IMM_W) zeros}; 3 SHIFT2 = sign-extend then shift left 2 (offset bits shifted out of the MSB end are dropped); 4 BRANCH = see Configuration; 5 ONES = {(DATA_W-IMM_W) ones, in_imm}; 6, 7 reserved -> out_data 0, out_err 1.
- All arithmetic is modulo 2^DATA_W; no overflow flag.
- Transfer in: in_valid && in_ready && rst_n && !flush. Transfer out: out_valid && out_ready.
- Storage: main register (drives outputs) plus one skid register. Extension is computed before storage; both entries hold final out_data/out_err.
- States: EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid).
  - EMPTY: accepted beat -> ONE.
  - ONE: accept without drain -> FULL (new beat into skid); accept with drain -> ONE (new beat into main); drain without accept -> EMPTY.
  - FULL: in_ready 0; drain -> ONE, skid moves into main.
- in_ready = 1 in EMPTY and ONE; 0 in FULL.
- Ordering strictly FIFO; no beat dropped or duplicated except by flush/reset.
- out_data/out_err hold their value while out_valid && !out_ready.

## Timing
- Reset (rst_n low at a clock edge): out_valid 0, out_data 0, out_err 0, in_ready 1, skid invalid. Beats presented while rst_n is low are ignored. Reset mid-stream discards both entries.
- Latency: a beat accepted at edge N is on out_data with out_valid 1 after edge N (visible in cycle N+1) when the stage was EMPTY.
- Throughput: one beat per cycle while out_ready stays 1.
- flush high at an edge: both entries invalidated, out_valid 0, out_err 0, in_ready 1 next cycle. Any beat presented that cycle is discarded. A same-cycle drain still counts as taken downstream.
- Flush and reset together: reset wins; the result is identical.
- out_data is 0 whenever out_valid is 0 after a flush or reset; otherwise it holds its last value.

## Configuration
- Macro IMM_EXT_BRANCH_ADD_EN.
- Defined: mode 4 BRANCH outputs in_pc + 4 + (sext(in_imm) << 2). The adder sits before the main/skid registers, so latency is unchanged.
- Undefined: no adder is built, in_pc is unused, and mode 4 behaves exactly as mode 3 SHIFT2.

## Test plan
- Reset: hold rst_n low 3 cycles with in_valid 1, in_imm 0x1234 -> throughout, out_valid 0, out_data 0, out_err 0; first cycle after release in_ready 1.
- Modes, out_ready 1, in_imm 0x8001 -> ZERO 0x00008001; SIGNED 0xFFFF8001; HIGHPOS 0x80010000; SHIFT2 0xFFFE0004; ONES 0xFFFF8001; each one cycle after acceptance, back-to-back at full rate.
- Backpressure, out_ready 0: beats A (ZERO 0x0001), B (ZERO 0x0002) accepted -> out_data 0x1 held, in_ready 0. Beat C is not accepted. Then out_ready 1 -> 0x1, 0x2, then C on consecutive cycles.
- Flush in FULL with in_valid 1 -> next cycle out_valid 0, in_ready 1, and that input beat never appears.
- BRANCH with in_pc 0x00400000, in_imm 0xFFFF -> with IMM_EXT_BRANCH_ADD_EN 0x00400000; without it 0xFFFFFFFC.
- Reserved mode 6, in_imm 0xFFFF -> out_data 0, out_err 1. The next beat, mode ZERO, returns out_err 0.
